data_mem_ctrl: RTL and testbench

//  Multi-cycle data-memory controller between the MEM pipeline stage and a word-wide SRAM with an ack handshake.
//  - Accepts MEM-stage load/store commands: MemRead, MemWrite, MemOp, MemEXT, address, din.
//  - Performs byte/half lane select and extension, and read-modify-write for sub-word stores.
//  - Holds the pipeline with stall until the access completes; returns load data on dout.

---
 rtl/data_mem_ctrl_if.sv | 36 +++
 rtl/data_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Bundle of MEM-stage command/response signals and the word-wide SRAM
// handshake; slave is the controller side, master is the surrounding system.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 30
);
    logic              MemRead;
    logic              MemWrite;
    logic [1:0]        MemOp;
    logic              MemEXT;
    logic [31:0]       address;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              stall;
    logic              misalign;
    logic              timeout;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  MemRead, MemWrite, MemOp, MemEXT, address, din,
        input  mem_rdata, mem_ack,
        output dout, stall, misalign, timeout,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, MemOp, MemEXT, address, din,
        output mem_rdata, mem_ack,
        input  dout, stall, misalign, timeout,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: lane select/extension for loads,
// read-modify-write for sub-word stores, pipeline stall and ack timeout.
module data_mem_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_lane;
    logic [1:0]        r_op;
    logic              r_ext;
    logic [31:0]       r_din;
    logic [31:0]       r_dout;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_misalign;
    logic              r_timeout;

    logic w_req;
    logic w_opWord;
    logic w_misaligned;
    logic w_busy;
    logic w_cntHit;
    logic w_stall;
    logic w_memReq;
    logic w_memWe;

    function automatic logic [31:0] extractLane(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] op, input logic ext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            2'b01:   res = {{16{ext & h[15]}}, h};
            2'b10:   res = {{24{ext & b[7]}}, b};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] op, input logic [31:0] data);
        logic [31:0] res;
        res = word;
        if (op == 2'b01) begin
            if (lane[1]) res[31:16] = data[15:0];
            else         res[15:0]  = data[15:0];
        end else if (op == 2'b10) begin
            res[{lane, 3'b000} +: 8] = data[7:0];
        end
        return res;
    endfunction

    assign w_req        = bus.MemRead | bus.MemWrite;
    assign w_opWord     = (bus.MemOp == 2'b00) || (bus.MemOp == 2'b11);
    assign w_misaligned = (w_opWord && (bus.address[1:0] != 2'b00)) ||
                          ((bus.MemOp == 2'b01) && bus.address[0]);
    assign w_busy       = (r_state == RD) || (r_state == RMW_RD) || (r_state == WR);
    assign w_cntHit     = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Handshake outputs come straight from state so a reset drops mem_req at once
    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_memReq = 1'b0;
        w_memWe  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall = rst;
                    if (w_misaligned)     w_next = DONE;
                    else if (!bus.MemWrite) w_next = RD;
                    else if (w_opWord)    w_next = WR;
                    else                  w_next = RMW_RD;
                end
            end
            RD: begin
                w_stall  = 1'b1;
                w_memReq = 1'b1;
                if (bus.mem_ack || w_cntHit) w_next = DONE;
            end
            RMW_RD: begin
                w_stall  = 1'b1;
                w_memReq = 1'b1;
                if (bus.mem_ack)   w_next = WR;
                else if (w_cntHit) w_next = DONE;
            end
            WR: begin
                w_stall  = 1'b1;
                w_memReq = 1'b1;
                w_memWe  = 1'b1;
                if (bus.mem_ack || w_cntHit) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Counter restarts whenever a new SRAM transaction phase begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_lane     <= 2'b00;
            r_op       <= 2'b00;
            r_ext      <= 1'b0;
            r_din      <= '0;
            r_dout     <= '0;
            r_wdata    <= '0;
            r_memAddr  <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= (w_busy && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_lane    <= bus.address[1:0];
                        r_op      <= bus.MemOp;
                        r_ext     <= bus.MemEXT;
                        r_din     <= bus.din;
                        r_wdata   <= bus.din;
                        r_memAddr <= bus.address[ADDR_W+1:2];
                        if (w_misaligned) begin
                            r_misalign <= 1'b1;
                            if (!bus.MemWrite) r_dout <= '0;
                        end
                    end
                end
                RD: begin
                    if (bus.mem_ack) begin
                        r_dout <= extractLane(bus.mem_rdata, r_lane, r_op, r_ext);
                    end else if (w_cntHit) begin
                        r_dout    <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                RMW_RD: begin
                    if (bus.mem_ack)   r_wdata   <= mergeLane(bus.mem_rdata, r_lane, r_op, r_din);
                    else if (w_cntHit) r_timeout <= 1'b1;
                end
                WR: begin
                    if (!bus.mem_ack && w_cntHit) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall     = w_stall;
    assign bus.mem_req   = w_memReq;
    assign bus.mem_we    = w_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_wdata;
    assign bus.dout      = r_dout;
    assign bus.misalign  = r_misalign;
    assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: acts as the SRAM and MEM stage, checks every
// access against an arithmetic reference model of memory and load results.
module tb_data_mem_ctrl;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(30)) bus();

    data_mem_ctrl #(.ADDR_W(30), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sram   [16];
    logic [31:0] refMem [16];
    logic [31:0] refDout = 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [1:0] op, input logic ext);
        logic [31:0] v;
        int sh;
        if (op == 2'd1) begin
            sh = 16 * int'(addr[1]);
            v  = (word >> sh) & 32'h0000FFFF;
            if (ext && v[15]) v = v | 32'hFFFF0000;
        end else if (op == 2'd2) begin
            sh = 8 * int'(addr[1:0]);
            v  = (word >> sh) & 32'h000000FF;
            if (ext && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] addr,
                                             input logic [1:0] op, input logic [31:0] data);
        logic [31:0] mask;
        int sh;
        if (op == 2'd1) begin
            sh   = 16 * int'(addr[1]);
            mask = 32'h0000FFFF << sh;
        end else if (op == 2'd2) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'h000000FF << sh;
        end else begin
            return data;
        end
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    // One MEM-stage access, from request through the DONE cycle, with the bench as SRAM
    task automatic applyStimulus(input logic isRd, input logic isWr, input logic [1:0] op,
                                 input logic ext, input logic [31:0] addr, input logic [31:0] data,
                                 input int delay, output int stallCnt);
        logic        isWord;
        logic        mis;
        logic        tmo;
        logic        sub;
        logic [3:0]  idx;
        logic [31:0] expW;
        int          expStall;
        int          expReq;
        int          expWr;
        int          reqCnt;
        int          wrCnt;
        int          run;
        logic        done;

        isWord = (op == 2'd0) || (op == 2'd3);
        mis    = (isWord && addr[1:0] != 2'd0) || (op == 2'd1 && addr[0]);
        tmo    = !mis && (delay >= TMO);
        sub    = isWr && !isWord;
        idx    = addr[5:2];
        expW   = refStore(refMem[idx], addr, op, data);
        if (mis) begin
            expStall = 1;
            expReq   = 0;
        end else if (tmo) begin
            expStall = 1 + TMO;
            expReq   = TMO;
        end else begin
            expStall = 1 + (sub ? 2 : 1) * (delay + 1);
            expReq   = (sub ? 2 : 1) * (delay + 1);
        end
        expWr = (isWr && !mis && !tmo) ? 1 : 0;
        if (!isWr) refDout = (mis || tmo) ? 32'h0 : refLoad(refMem[idx], addr, op, ext);
        else if (expWr == 1) refMem[idx] = expW;

        @(negedge clk);
        bus.MemRead  = isRd;
        bus.MemWrite = isWr;
        bus.MemOp    = op;
        bus.MemEXT   = ext;
        bus.address  = addr;
        bus.din      = data;
        bus.mem_ack  = 1'b0;
        stallCnt = 0;
        reqCnt   = 0;
        wrCnt    = 0;
        run      = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            bus.mem_ack = 1'b0;
            if (bus.stall) begin
                stallCnt++;
                if (bus.mem_req) begin
                    reqCnt++;
                    if (run == 0) checkOutput("memAddr", {2'b00, bus.mem_addr}, addr >> 2);
                    if (run >= delay) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = sram[bus.mem_addr[3:0]];
                        if (bus.mem_we) begin
                            wrCnt++;
                            checkOutput("memWdata", bus.mem_wdata, expW);
                            sram[bus.mem_addr[3:0]] = bus.mem_wdata;
                        end
                        run = 0;
                    end else begin
                        run++;
                    end
                end
            end else begin
                done = 1'b1;
                checkOutput("misalign", {31'b0, bus.misalign}, {31'b0, mis});
                checkOutput("timeout", {31'b0, bus.timeout}, {31'b0, tmo});
                checkOutput("dout", bus.dout, refDout);
                checkOutput("stallCycles", stallCnt, expStall);
                checkOutput("reqCycles", reqCnt, expReq);
                checkOutput("writes", wrCnt, expWr);
                checkOutput("memReqDone", {31'b0, bus.mem_req}, 32'h0);
            end
            if (!done) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!done) checkOutput("doneReached", 32'h0, 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        int          stalls;
        logic [1:0]  op;
        logic [31:0] addr;
        int          sel;

        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.MemOp     = 2'b00;
        bus.MemEXT    = 1'b0;
        bus.address   = 32'h0;
        bus.din       = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sram[i]   = $urandom;
            refMem[i] = sram[i];
        end

        // Reset state, with a request pending that must not raise stall
        #12;
        checkOutput("rstStall", {31'b0, bus.stall}, 32'h0);
        checkOutput("rstReq", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rstWe", {31'b0, bus.mem_we}, 32'h0);
        checkOutput("rstAddr", {2'b00, bus.mem_addr}, 32'h0);
        checkOutput("rstWdata", bus.mem_wdata, 32'h0);
        checkOutput("rstDout", bus.dout, 32'h0);
        checkOutput("rstFlags", {30'b0, bus.misalign, bus.timeout}, 32'h0);
        bus.MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Word load with ack on the third request cycle
        sram[4] = 32'hDEADBEEF;
        refMem[4] = 32'hDEADBEEF;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 2, stalls);
        checkOutput("t1Stall", stalls, 32'd4);
        checkOutput("t1Dout", bus.dout, 32'hDEADBEEF);

        // Byte loads, signed and unsigned
        sram[4] = 32'h80123456;
        refMem[4] = 32'h80123456;
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b1, 32'h13, 32'h0, 0, stalls);
        checkOutput("t2Sext", bus.dout, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, stalls);
        checkOutput("t2Zext", bus.dout, 32'h00000080);

        // Half store read-modify-write
        sram[8] = 32'h11223344;
        refMem[8] = 32'h11223344;
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, 0, stalls);
        checkOutput("t3Stall", stalls, 32'd3);
        checkOutput("t3Word", sram[8], 32'hABCD3344);

        // Misaligned word load and half store
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h06, 32'h0, 0, stalls);
        checkOutput("t4LoadDout", bus.dout, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h05, 32'h12345678, 0, stalls);
        checkOutput("t4StoreStall", stalls, 32'd1);

        // Word store with no ack ever
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h30, 32'hCAFEF00D, 99, stalls);
        checkOutput("t5Stall", stalls, 32'd5);

        // Randomized mix, including both-high as store and occasional timeouts
        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 63));
            sel  = $urandom_range(1, 3);
            applyStimulus(sel != 2, sel != 1, op, 1'($urandom_range(0, 1)), addr, $urandom,
                          $urandom_range(0, 5), stalls);
        end

        // Reset in the middle of a word store write phase
        @(negedge clk);
        bus.MemWrite = 1'b1;
        bus.MemOp    = 2'd0;
        bus.address  = 32'h3C;
        bus.din      = 32'h55AA55AA;
        bus.mem_ack  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t6ReqBefore", {31'b0, bus.mem_req & bus.mem_we}, 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("t6ReqDrop", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("t6StallDrop", {31'b0, bus.stall}, 32'h0);
        bus.MemWrite = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        refDout = 32'h0;
        checkOutput("t6Dout", bus.dout, 32'h0);
        checkOutput("t6Outs", {28'b0, bus.stall, bus.mem_we, bus.misalign, bus.timeout}, 32'h0);
        checkOutput("t6Addr", {2'b00, bus.mem_addr}, 32'h0);
        checkOutput("t6Wdata", bus.mem_wdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h3C, 32'h0, 1, stalls);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
